// File: rtl/hdmi_text_axi_regs.sv
// hdmi_text_axi_regs: AXI4-Lite slave holding 600 text VRAM words plus one control word,
// with a registered video-side read port and a direct view of the control word.
module hdmi_text_axi_regs #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 16,
    parameter int NUM_VRAM         = 600
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [2:0]                    axi_awprot,
    input  logic                          axi_awvalid,
    output logic                          axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                          axi_wvalid,
    output logic                          axi_wready,
    output logic [1:0]                    axi_bresp,
    output logic                          axi_bvalid,
    input  logic                          axi_bready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [2:0]                    axi_arprot,
    input  logic                          axi_arvalid,
    output logic                          axi_arready,
    output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]                    axi_rresp,
    output logic                          axi_rvalid,
    input  logic                          axi_rready,
    input  logic [9:0]                    vid_addr,
    output logic [C_AXI_DATA_WIDTH-1:0]   vid_data,
    output logic [C_AXI_DATA_WIDTH-1:0]   ctrl_reg
);
    localparam logic [9:0] LAST = 10'(NUM_VRAM);

    logic [C_AXI_DATA_WIDTH-1:0]   mem [0:NUM_VRAM];
    logic                          en, aw_full, w_full;
    logic [C_AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [C_AXI_DATA_WIDTH-1:0]   w_data;
    logic [C_AXI_DATA_WIDTH/8-1:0] w_strb;
    logic [9:0]                    aw_idx, ar_idx;
    logic                          aw_ok, ar_ok, commit;
    logic                          unused;

    assign unused = ^{axi_awprot, axi_arprot, aw_addr[1:0], axi_araddr[1:0]};

    assign aw_idx = aw_addr[11:2];
    assign ar_idx = axi_araddr[11:2];
    assign aw_ok  = aw_addr[C_AXI_ADDR_WIDTH-1:12] == '0 && aw_idx <= LAST;
    assign ar_ok  = axi_araddr[C_AXI_ADDR_WIDTH-1:12] == '0 && ar_idx <= LAST;
    assign commit = aw_full & w_full;

    assign axi_awready = en & ~aw_full & ~axi_bvalid;
    assign axi_wready  = en & ~w_full & ~axi_bvalid;
    assign axi_arready = en & ~axi_rvalid;
    assign ctrl_reg    = mem[NUM_VRAM];

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i <= NUM_VRAM; i++) mem[i] <= '0;
            en         <= 1'b0;
            aw_full    <= 1'b0;
            w_full     <= 1'b0;
            aw_addr    <= '0;
            w_data     <= '0;
            w_strb     <= '0;
            axi_bvalid <= 1'b0;
            axi_bresp  <= 2'b00;
            axi_rvalid <= 1'b0;
            axi_rresp  <= 2'b00;
            axi_rdata  <= '0;
            vid_data   <= '0;
        end else begin
            en <= 1'b1;
            if (axi_awvalid && axi_awready) begin
                aw_addr <= axi_awaddr;
                aw_full <= 1'b1;
            end
            if (axi_wvalid && axi_wready) begin
                w_data <= axi_wdata;
                w_strb <= axi_wstrb;
                w_full <= 1'b1;
            end
            if (commit) begin
                aw_full    <= 1'b0;
                w_full     <= 1'b0;
                axi_bvalid <= 1'b1;
                axi_bresp  <= aw_ok ? 2'b00 : 2'b10;
                if (aw_ok)
                    for (int b = 0; b < C_AXI_DATA_WIDTH/8; b++)
                        if (w_strb[b]) mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
            end else if (axi_bvalid && axi_bready) begin
                axi_bvalid <= 1'b0;
            end
            // reads sample mem before this edge's commit lands, so a colliding read sees old data
            if (axi_arvalid && axi_arready) begin
                axi_rvalid <= 1'b1;
                axi_rdata  <= ar_ok ? mem[ar_idx] : '0;
                axi_rresp  <= ar_ok ? 2'b00 : 2'b10;
            end else if (axi_rvalid && axi_rready) begin
                axi_rvalid <= 1'b0;
            end
            vid_data <= vid_addr <= LAST ? mem[vid_addr] : '0;
        end
    end
endmodule

// File: tb/tb_hdmi_text_axi_regs.sv
// tb_hdmi_text_axi_regs: scoreboard bench for the HDMI text AXI register file.
module tb_hdmi_text_axi_regs;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] axi_awaddr = '0, axi_araddr = '0;
    logic [2:0]  axi_awprot = '0, axi_arprot = '0;
    logic        axi_awvalid = 1'b0, axi_wvalid = 1'b0, axi_bready = 1'b0;
    logic        axi_arvalid = 1'b0, axi_rready = 1'b0;
    logic [31:0] axi_wdata = '0;
    logic [3:0]  axi_wstrb = '0;
    logic [9:0]  vid_addr = '0;
    logic        axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid;
    logic [1:0]  axi_bresp, axi_rresp;
    logic [31:0] axi_rdata, vid_data, ctrl_reg;

    int          n_tests = 0, n_fail = 0;
    int          lat;
    logic [33:0] rq [$];
    logic [1:0]  bq [$];
    logic [31:0] model [0:600];

    always #5 clk = ~clk;

    hdmi_text_axi_regs dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .vid_addr(vid_addr), .vid_data(vid_data), .ctrl_reg(ctrl_reg)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] expect_rd(input logic [15:0] a);
        if (a[15:12] == 4'h0 && a[11:2] <= 10'd600) return {2'b00, model[a[11:2]]};
        return {2'b10, 32'h0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model;
        for (int i = 0; i <= 600; i++) model[i] = '0;
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W; bdly < 0 leaves bvalid pending
    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, input int bdly, output int blat);
        int t = 0;
        bit awd = 0, wd = 0, ha, hw;
        logic [33:0] e;
        e = expect_rd(a);
        axi_awaddr = a;
        axi_wdata  = d;
        axi_wstrb  = s;
        while (!(awd && wd) && t < 100) begin
            axi_awvalid = !awd && t >= (lead > 0 ? lead : 0);
            axi_wvalid  = !wd && t >= (lead < 0 ? -lead : 0);
            @(negedge clk);
            ha = axi_awvalid & axi_awready;
            hw = axi_wvalid & axi_wready;
            tick;
            awd |= ha;
            wd  |= hw;
            t++;
        end
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        if (t >= 100) chk("aw_w_timeout", 64'(t), 0);
        bq.push_back(e[33:32]);
        if (e[33:32] == 2'b00)
            for (int b = 0; b < 4; b++) if (s[b]) model[a[11:2]][8*b +: 8] = d[8*b +: 8];
        blat = 0;
        while (!axi_bvalid && blat < 50) begin
            tick;
            blat++;
        end
        if (bdly < 0) return;
        repeat (bdly) tick;
        axi_bready = 1'b1;
        t = 0;
        while (bq.size() != 0 && t < 50) begin
            tick;
            t++;
        end
        axi_bready = 1'b0;
        if (t >= 50) chk("b_timeout", 64'(bq.size()), 0);
    endtask

    task automatic axi_read(input logic [15:0] a, input int rdly);
        int t = 0;
        bit h = 0;
        rq.push_back(expect_rd(a));
        axi_araddr  = a;
        axi_arvalid = 1'b1;
        while (!h && t < 50) begin
            @(negedge clk);
            h = axi_arready;
            tick;
            t++;
        end
        axi_arvalid = 1'b0;
        if (!h) chk("ar_timeout", 64'(t), 0);
        t = 0;
        while (!axi_rvalid && t < 50) begin
            tick;
            t++;
        end
        repeat (rdly) tick;
        axi_rready = 1'b1;
        t = 0;
        while (rq.size() != 0 && t < 50) begin
            tick;
            t++;
        end
        axi_rready = 1'b0;
        if (t >= 50) chk("r_timeout", 64'(rq.size()), 0);
    endtask

    // rdata/rresp are compared every cycle rvalid is up, so a stalled response must hold still
    always @(negedge clk) begin
        logic [1:0]  eb;
        logic [33:0] er;
        if (rst_n) begin
            if (axi_bvalid && axi_bready) begin
                if (bq.size() == 0) chk("b_spurious", 64'(bq.size()), 1);
                else begin
                    eb = bq.pop_front();
                    chk("bresp", 64'(axi_bresp), 64'(eb));
                end
            end
            if (axi_rvalid) begin
                if (rq.size() == 0) chk("r_spurious", 64'(rq.size()), 1);
                else begin
                    er = rq[0];
                    chk("rdata", 64'(axi_rdata), 64'(er[31:0]));
                    chk("rresp", 64'(axi_rresp), 64'(er[33:32]));
                    if (axi_rready) void'(rq.pop_front());
                end
            end
        end
    end

    initial begin
        clear_model();
        repeat (3) tick;
        chk("rst_awready", 64'(axi_awready), 0);
        chk("rst_wready", 64'(axi_wready), 0);
        chk("rst_arready", 64'(axi_arready), 0);
        chk("rst_bvalid", 64'(axi_bvalid), 0);
        chk("rst_rvalid", 64'(axi_rvalid), 0);
        chk("rst_rdata", 64'(axi_rdata), 0);
        chk("rst_ctrl", 64'(ctrl_reg), 0);
        chk("rst_vid", 64'(vid_data), 0);
        rst_n = 1'b1;
        chk("first_awready", 64'(axi_awready), 0);
        chk("first_arready", 64'(axi_arready), 0);
        tick;
        chk("en_awready", 64'(axi_awready), 1);
        chk("en_wready", 64'(axi_wready), 1);
        chk("en_arready", 64'(axi_arready), 1);

        axi_read(16'h0960, 0);
        axi_write(16'h0960, 32'h001F6000, 4'hF, 0, 0, lat);
        chk("blat_same", 64'(lat), 1);
        chk("ctrl_set", 64'(ctrl_reg), 64'h001F6000);
        axi_read(16'h0960, 0);

        axi_write(16'h0004, 32'hAABBCCDD, 4'hF, 3, 1, lat);
        chk("blat_wfirst", 64'(lat), 1);
        axi_write(16'h0004, 32'h11223344, 4'b0101, -2, 0, lat);
        chk("blat_awfirst", 64'(lat), 1);
        axi_read(16'h0004, 2);
        axi_write(16'h0006, 32'hFFFFFFFF, 4'h0, 0, 0, lat);
        axi_read(16'h0004, 1);

        for (int i = 0; i < 600; i++)
            axi_write(16'(i * 4), 32'(i), 4'hF, int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 2)), lat);
        for (int i = 0; i < 600; i++) axi_read(16'(i * 4), int'($urandom_range(0, 3)));

        axi_write(16'h0964, 32'h12345678, 4'hF, 0, 0, lat);
        axi_write(16'h1000, 32'hCAFEF00D, 4'hF, 1, 0, lat);
        axi_read(16'h0964, 1);
        axi_read(16'h1000, 0);
        axi_read(16'h0000, 0);
        chk("ctrl_keep", 64'(ctrl_reg), 64'(model[600]));

        axi_write(16'h0014, 32'hDEADBEEF, 4'hF, 0, 0, lat);
        vid_addr = 10'd5;
        tick;
        chk("vid_5", 64'(vid_data), 64'(model[5]));
        vid_addr = 10'd700;
        tick;
        chk("vid_700", 64'(vid_data), 0);
        vid_addr = 10'd600;
        tick;
        chk("vid_600", 64'(vid_data), 64'(model[600]));

        axi_write(16'h0014, 32'h12345678, 4'hF, 0, -1, lat);
        chk("b_pending", 64'(axi_bvalid), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_b_drop", 64'(axi_bvalid), 0);
        chk("rst_ctrl_clr", 64'(ctrl_reg), 0);
        bq.delete();
        clear_model();
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        axi_read(16'h0014, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
